// File: rtl/imm_operand_encoder.sv
// -----------------------------------------------------------------------------
// imm_operand_encoder
//   Finds the 12-bit shifter_operand encoding for a 32-bit constant. This is
//   the inverse of the execute-stage Val2 operand generator.
//   - ld_str=0 (data-processing immediate): the constant must equal
//     ROR({24'b0,immed_8}, 2*rotate_imm). The search tries one rotation per
//     cycle, starting at rotate_imm=0. The first hit wins, so the encoding
//     returned is unique.
//   - ld_str=1 (load/store offset): the constant must be a sign-extended
//     12-bit value. This check takes a single SEARCH cycle.
//
// Handshake: a request is accepted only on a cycle where start=1 and busy=0.
//   value and ld_str are captured on that edge. While busy=1, start, value and
//   ld_str are ignored. done is a one-cycle pulse that marks found and
//   shift_operand valid. Those two outputs then hold until the next search
//   completes.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous reset, active-high
//   start          in   1   request pulse (sampled in IDLE only)
//   ld_str         in   1   0 = rotate-immediate search, 1 = signed-12 check
//   value          in   32  constant to encode
//   busy           out  1   high in SEARCH and DONE
//   done           out  1   one-cycle result-valid pulse
//   found          out  1   an encoding exists
//   shift_operand  out  12  {rotate_imm,immed_8} or value[11:0]; 0 if !found
//   dbg_state      out  2   current FSM state (0=IDLE, 1=SEARCH, 2=DONE)
// -----------------------------------------------------------------------------
module imm_operand_encoder #(
   parameter int ROT_STEPS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ld_str,
   input  logic [31:0] value,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic [11:0] shift_operand,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

   state_t      state_q, state_d;
   logic [3:0]  rot_q, rot_d;
   logic [31:0] value_q, value_d;
   logic        ld_str_q, ld_str_d;
   logic        found_q, found_d;
   logic [11:0] op_q, op_d;

   // Left-rotate by 2*rot. Shifting the doubled word left and keeping the
   // upper half avoids a shift-by-32 corner case when rot is 0.
   logic [4:0]  rot_amt;
   logic [63:0] dbl_shift;
   logic [31:0] cand;
   logic        sext12_ok;

   assign rot_amt   = {rot_q, 1'b0};
   assign dbl_shift = {value_q, value_q} << rot_amt;
   assign cand      = dbl_shift[63:32];

   // The value is a sign-extended 12-bit offset when bits 31..11 are all copies
   // of the sign bit.
   assign sext12_ok = (value_q[31:11] == '0) || (value_q[31:11] == '1);

   always_comb begin
      state_d  = state_q;
      rot_d    = rot_q;
      value_d  = value_q;
      ld_str_d = ld_str_q;
      found_d  = found_q;
      op_d     = op_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               value_d  = value;
               ld_str_d = ld_str;
               rot_d    = '0;
               state_d  = SEARCH;
            end
         end
         SEARCH: begin
            if (ld_str_q) begin
               found_d = sext12_ok;
               op_d    = sext12_ok ? value_q[11:0] : 12'h000;
               state_d = DONE;
            end else if (cand[31:8] == '0) begin
               found_d = 1'b1;
               op_d    = {rot_q, cand[7:0]};
               state_d = DONE;
            end else if (rot_q == ROT_LAST) begin
               found_d = 1'b0;
               op_d    = 12'h000;
               state_d = DONE;
            end else begin
               rot_d = rot_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rot_q    <= '0;
         value_q  <= '0;
         ld_str_q <= 1'b0;
         found_q  <= 1'b0;
         op_q     <= '0;
      end else begin
         state_q  <= state_d;
         rot_q    <= rot_d;
         value_q  <= value_d;
         ld_str_q <= ld_str_d;
         found_q  <= found_d;
         op_q     <= op_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign found         = found_q;
   assign shift_operand = op_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_operand_encoder
//   Directed bench for imm_operand_encoder. Each request is issued from IDLE.
//   The bench then counts cycles until done and compares latency, found,
//   shift_operand and the post-done idle state against hand-computed values.
// -----------------------------------------------------------------------------
module tb_imm_operand_encoder;

   logic        clk;
   logic        rst;
   logic        start;
   logic        ld_str;
   logic [31:0] value;
   logic        busy;
   logic        done;
   logic        found;
   logic [11:0] shift_operand;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   imm_operand_encoder #(.ROT_STEPS(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .ld_str        (ld_str),
      .value         (value),
      .busy          (busy),
      .done          (done),
      .found         (found),
      .shift_operand (shift_operand),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from an IDLE cycle and wait for done. Cycle numbering
   // follows the start edge: the cycle right after that edge is cycle 1.
   // When poke is set, a junk start with a different value and mode is
   // pulsed in cycle 3. The result must not depend on it.
   task automatic run_op(input string tag, input logic [31:0] v, input logic ls,
                         input int exp_cyc, input logic exp_found,
                         input logic [11:0] exp_op, input logic poke);
      int cyc;
      start  = 1'b1;
      value  = v;
      ld_str = ls;
      step();
      start  = 1'b0;
      value  = ~v;
      ld_str = ~ls;
      cyc    = 1;
      check({tag, "_busy_c1"}, 32'(busy), 32'd1);
      while (!done && cyc < 40) begin
         if (poke && cyc == 3) begin
            start  = 1'b1;
            value  = 32'h0000_00FF;
            ld_str = 1'b1;
         end else begin
            start  = 1'b0;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_found"}, 32'(found), 32'(exp_found));
      check({tag, "_operand"}, 32'(shift_operand), 32'(exp_op));
      step();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_hold_operand"}, 32'(shift_operand), 32'(exp_op));
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      ld_str = 1'b0;
      value  = '0;
      step();
      step();
      rst = 1'b0;
      check("reset_busy",  32'(busy), 32'd0);
      check("reset_done",  32'(done), 32'd0);
      check("reset_found", 32'(found), 32'd0);
      check("reset_op",    32'(shift_operand), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);

      // Mode-1 rotation search. Each call begins in the idle cycle left by the
      // previous one, so requests run back to back.
      run_op("m1_ff",       32'h0000_00FF, 1'b0, 2,  1'b1, 12'h0FF, 1'b0);
      run_op("m1_ff000000", 32'hFF00_0000, 1'b0, 6,  1'b1, 12'h4FF, 1'b0);
      run_op("m1_3fc",      32'h0000_03FC, 1'b0, 17, 1'b1, 12'hFFF, 1'b0);
      run_op("m1_miss",     32'h0000_0102, 1'b0, 17, 1'b0, 12'h000, 1'b0);
      run_op("m1_zero",     32'h0000_0000, 1'b0, 2,  1'b1, 12'h000, 1'b0);
      // 0xC000003F: ROL by 2 gives 0xFF at rotation 1.
      run_op("m1_wrap",     32'hC000_003F, 1'b0, 3,  1'b1, 12'h1FF, 1'b0);

      // Mode-3 signed-12 check
      run_op("m3_neg",   32'hFFFF_F800, 1'b1, 2, 1'b1, 12'h800, 1'b0);
      run_op("m3_miss",  32'h0000_0800, 1'b1, 2, 1'b0, 12'h000, 1'b0);
      run_op("m3_pos",   32'h0000_07FF, 1'b1, 2, 1'b1, 12'h7FF, 1'b0);

      // A start pulse while busy is ignored, and so are input changes.
      run_op("busy_poke", 32'h0000_03FC, 1'b0, 17, 1'b1, 12'hFFF, 1'b1);

      // Reset mid-search: the outputs clear and no done pulse follows.
      start  = 1'b1;
      value  = 32'hFF00_0000;
      ld_str = 1'b0;
      step();
      start = 1'b0;
      step();
      check("mid_busy", 32'(busy), 32'd1);
      rst   = 1'b1;
      start = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_mid_busy",  32'(busy), 32'd0);
      check("rst_mid_found", 32'(found), 32'd0);
      check("rst_mid_op",    32'(shift_operand), 32'd0);
      check("rst_mid_state", 32'(dbg_state), 32'd0);
      begin
         int seen_done = 0;
         for (int i = 0; i < 10; i++) begin
            if (done) seen_done++;
            step();
         end
         check("rst_mid_no_done", 32'(seen_done), 32'd0);
      end

      // The encoder still works after the abort.
      run_op("post_rst", 32'hFF00_0000, 1'b0, 6, 1'b1, 12'h4FF, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
